// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: widths, column payload, GF(2^8) helpers and
// the MixColumns sequencer state encoding.
package aes_pkg;

  localparam int unsigned AES_STATE_W  = 128;
  localparam int unsigned AES_COL_W    = 32;
  localparam int unsigned AES_NUM_COLS = AES_STATE_W / AES_COL_W;
  localparam logic [7:0]  AES_GF_POLY  = 8'h1b;

  // One state column; row 0 sits in the least significant byte.
  typedef struct packed {
    logic [7:0] r3;
    logic [7:0] r2;
    logic [7:0] r1;
    logic [7:0] r0;
  } aes_col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mix_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational forward MixColumns of one 32-bit column.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col,
  output logic [AES_COL_W-1:0] mixed
);

  aes_col_t a;
  aes_col_t b;

  always_comb begin
    a    = aes_col_t'(col);
    b.r0 = xtime(a.r0) ^ mul3(a.r1) ^ a.r2        ^ a.r3;
    b.r1 = a.r0        ^ xtime(a.r1) ^ mul3(a.r2) ^ a.r3;
    b.r2 = a.r0        ^ a.r1        ^ xtime(a.r2) ^ mul3(a.r3);
    b.r3 = mul3(a.r0)  ^ a.r1        ^ a.r2        ^ xtime(a.r3);
  end

  assign mixed = b;

endmodule

// File: rtl/mix_column_seq.sv
// Column-serial AES MixColumns with valid/ready on both sides; COLS_PER_CYCLE
// column engines are time-shared over the four columns of a working register.
module mix_column_seq
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'(AES_NUM_COLS - COLS_PER_CYCLE);

  mix_state_t state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [AES_NUM_COLS-1:0][AES_COL_W-1:0] work_q, work_d;

  logic [1:0]           eng_idx [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] eng_out [COLS_PER_CYCLE];

  // Engine e works on column col_idx+e of the current group.
  for (genvar e = 0; e < COLS_PER_CYCLE; e++) begin : g_eng
    assign eng_idx[e] = col_idx_q + 2'(e);
    mix_single_column u_col (
      .col   (work_q[eng_idx[e]]),
      .mixed (eng_out[e])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_idx_q <= 2'd0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      work_q    <= work_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d    = in_state;
          col_idx_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int e = 0; e < int'(COLS_PER_CYCLE); e++) begin
          work_d[eng_idx[e]] = eng_out[e];
        end
        if (col_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          col_idx_d = col_idx_q + COL_STEP;
        end
      end
      DONE: begin
        // Draining and refilling in the same cycle keeps back-to-back throughput.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d    = in_state;
            col_idx_d = 2'd0;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign out_state = work_q;

endmodule

// File: tb/tb_mix_column_seq.sv
// Directed and randomized bench for mix_column_seq with 1, 2 and 4 column engines.
module tb_mix_column_seq;

  localparam int unsigned NDUT = 3;

  localparam logic [127:0] T1_IN   = 128'h0000_0000_0000_0000_0000_0000_4553_13db;
  localparam logic [127:0] T1_OUT  = 128'h0000_0000_0000_0000_0000_0000_bca1_4d8e;
  localparam logic [127:0] T2_IN   = 128'h4c31_262d_d5d4_d4d4_c6c6_c6c6_5c22_0af2;
  localparam logic [127:0] T2_OUT  = 128'hf8bd_7e4d_d6d7_d5d5_c6c6_c6c6_9d58_dc9f;
  localparam logic [127:0] ONES    = {4{32'h0101_0101}};
  localparam logic [127:0] GARBAGE = {4{32'hdead_beef}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_state  [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_state [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    mix_column_seq #(.COLS_PER_CYCLE(CPC)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant-matrix reference; inv selects the inverse MixColumns coefficients.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0]   k [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[c*32 + i*8 +: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], k[(j - rr + 4) % 4]);
        r[c*32 + rr*8 +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Accept one state, scramble the input afterwards, and measure edges to out_valid.
  task automatic run_one(input int d, input logic [127:0] st, input logic [127:0] exp,
                         input int lat, input string tag);
    int edges;
    @(negedge clk);
    check({tag, " in_ready"}, 128'(in_ready[d]), 128'd1);
    in_valid[d] = 1'b1;
    in_state[d] = st;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_state[d] = GARBAGE;
    edges = 0;
    while (!out_valid[d] && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, 128'(edges), 128'(lat));
    check({tag, " result"}, out_state[d], exp);
  endtask

  task automatic wait_valid(input int d, input string tag);
    int n;
    n = 0;
    while (!out_valid[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " out_valid"}, 128'(out_valid[d]), 128'd1);
  endtask

  logic [127:0] q [$];
  logic [127:0] pexp;
  logic [127:0] prev_os;
  bit           prev_stall;
  bit           acc_last;
  int           sent;
  int           got;
  int           cyc;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_state[i]  = '0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reset out_valid", 128'(out_valid[i]), 128'd0);
      check("reset out_state", out_state[i], 128'd0);
      check("reset in_ready", 128'(in_ready[i]), 128'd1);
    end

    run_one(0, T1_IN, T1_OUT, 4, "single column cpc1");
    run_one(0, T2_IN, T2_OUT, 4, "full state cpc1");
    run_one(1, T2_IN, T2_OUT, 2, "full state cpc2");
    run_one(2, T2_IN, T2_OUT, 1, "full state cpc4");
    run_one(1, T1_IN, T1_OUT, 2, "single column cpc2");
    run_one(2, T1_IN, T1_OUT, 1, "single column cpc4");
    run_one(0, 128'h0, 128'h0, 4, "all zero");
    run_one(0, ONES, ONES, 4, "all ones");
    run_one(2, ONES, ONES, 1, "all ones cpc4");

    // Backpressure: result must sit untouched while a new state waits.
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_state[0]  = T2_IN;
    @(negedge clk);
    in_state[0]  = ONES;
    wait_valid(0, "bp");
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", 128'(out_valid[0]), 128'd1);
      check("bp in_ready", 128'(in_ready[0]), 128'd0);
      check("bp out_state", out_state[0], T2_OUT);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    in_state[0]  = T1_IN;
    #1;
    check("bp same-cycle in_ready", 128'(in_ready[0]), 128'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_state[0] = GARBAGE;
    check("bp refill busy", 128'(out_valid[0]), 128'd0);
    wait_valid(0, "bp refill");
    check("bp refill result", out_state[0], T1_OUT);

    // Reset while col_idx is 2.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = T2_IN;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midbusy rst out_valid", 128'(out_valid[0]), 128'd0);
    check("midbusy rst out_state", out_state[0], 128'd0);
    check("midbusy rst in_ready", 128'(in_ready[0]), 128'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midbusy rst no output", 128'(out_valid[0]), 128'd0);
    end
    run_one(0, T2_IN, T2_OUT, 4, "after reset");

    // Random stream with random stalls on both sides.
    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    acc_last = 1'b0;
    prev_os = '0;
    while (got < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check("stream hold valid", 128'(out_valid[0]), 128'd1);
        check("stream hold data", out_state[0], prev_os);
      end
      if (acc_last) in_valid[0] = 1'b0;
      if (!in_valid[0] && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid[0] = 1'b1;
        in_state[0] = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready[0] = ($urandom_range(0, 2) != 0);
      #1;
      acc_last = in_valid[0] && in_ready[0];
      if (acc_last) begin
        q.push_back(in_state[0]);
        sent++;
      end
      prev_stall = out_valid[0] && !out_ready[0];
      prev_os = out_state[0];
      if (out_valid[0] && out_ready[0]) begin
        check("stream pending", 128'(q.size() > 0), 128'd1);
        if (q.size() > 0) begin
          pexp = q.pop_front();
          check("stream forward", out_state[0], mix_model(pexp, 1'b0));
          check("stream inverse", mix_model(out_state[0], 1'b1), pexp);
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    check("stream count", 128'(got), 128'd1000);
    check("stream leftover", 128'(q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
